unit_propagate: RTL
===================

# unit_propagate

Applies one assigned literal to a CNF formula, producing the simplified formula for the next DPLL step. Consumes the literal reported by the unit-clause search block (lit_found) together with the same formula, scans clauses one per cycle, drops satisfied clauses and strips falsified literals. Reports conflict (empty clause) or satisfaction (empty formula) to the solver controller.

## Interface

- Parameters: none. Sizes come from `common`: `NUMBER_CLAUSES`, `CLAUSE_WIDTH` (max literals per clause), `VAR_WIDTH`.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset. One clock, synchronous active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `in_formula`  in  formula  formula to simplify; captured at accept.
- `in_lit`  in  lit  literal assigned true; captured at accept.
- `ended`  out  1  one-cycle pulse: result valid.
- `conflict`  out  1  an empty clause was produced; valid with `ended`, held until next accept.
- `sat`  out  1  result formula has zero clauses and no conflict; valid with `ended`, held until next accept.
- `out_formula`  out  formula  simplified formula; held until next accept.

## Operation

- States: IDLE, SCAN.
- IDLE + `start`=1: latch `in_formula`, `in_lit`; clear read index i, write index j, `conflict`, `sat`; `out_formula` ← `ZERO_FORMULA`; go to SCAN.
- `start` in SCAN is ignored; the captured inputs are not re-sampled.
- SCAN, each cycle, clause i (only when i < len):
  - If clause contains `in_lit` (same var, same polarity) → dropped; j unchanged.
  - Else remove every occurrence of ¬`in_lit`, compact the remaining literals in original order, and zero the slots at or above the new len. Write the result to `out_formula.clauses[j]`, j+1.
  - Reduced len = 0 → `conflict`=1; stop immediately; later clauses are not processed.
- Termination: after clause len−1, on a conflict, or immediately if len = 0. Then `out_formula.len` ← j, `sat` ← (j = 0 and no conflict), `ended` ← 1, return to IDLE.
- Only `lits[0..len-1]` of a clause are examined. Duplicate literals are handled by the remove-all rule.
- Literal equality compares both var and polarity. Negation flips polarity only.

## Timing

- Reset values: `ended`=0, `conflict`=0, `sat`=0, `out_formula`=`ZERO_FORMULA`, state IDLE.
- Edge E0 accepts `start`. Edge Ek (k≥1) processes clause k−1.
- `ended` is registered high after edge E_max(len,1). On a conflict at clause c, it is high after E_(c+1).
- `ended` is high for exactly one cycle. The state is already IDLE during that cycle, so `start` then is accepted (back-to-back, no bubble).
- `reset` mid-SCAN: next cycle IDLE, all outputs at reset values, no `ended` pulse.
- `in_formula` and `in_lit` may change freely after E0.

## Structure

- `common` adds:
  - `lit` as packed {neg, var[VAR_WIDTH]}.
  - `clause` as {lits[CLAUSE_WIDTH], len}.
  - `formula` as {clauses[NUMBER_CLAUSES], len}.
  - Constants `ZERO_LIT`, `ZERO_CLAUSE`, `ZERO_FORMULA`, `CLAUSE_WIDTH`, `VAR_WIDTH`.
  - Function `lit_neg`.
- Sub-module `clause_reduce` (combinational): inputs clause and lit; outputs `satisfied`, reduced clause, `empty`. The top module holds the FSM, the indices and the output registers.

## Test plan

- Formula {(+1,−2),(+2),(−1,+3)}, lit +2 → `ended` after E3; out = {(+1),(−1,+3)}, len 2; `conflict`=0, `sat`=0.
- Formula {(+1),(−1,+2)}, lit −1 → `ended` after E1; `conflict`=1, `sat`=0; clause 1 untouched (out len 0).
- Formula {(+4),(+4,−5)}, lit +4 → `ended` after E2; out len 0; `sat`=1.
- Formula len 0, lit +7 → `ended` after E1; `sat`=1. A second `start` during the `ended` cycle is accepted and completes normally.
- Full capacity: `NUMBER_CLAUSES` clauses, clause 0 = (−3,−3,+1), lit +3 → out clause 0 = (+1), len 1, upper slots zero; `ended` after E_NUMBER_CLAUSES.
- Two cases:
  - `start` pulsed again at E2 of a 3-clause scan → ignored; result matches the first request.
  - `reset` asserted at E2 → all outputs zero next cycle, no `ended` pulse.

Source files
------------

// File: rtl/unit_propagate_pkg.sv
// Shared types and sizes for the unit-propagation step of the DPLL solver.
// Provides literal/clause/formula payload structs, their zero constants,
// the FSM state type and the literal negation helper.
package unit_propagate_pkg;

    localparam int unsigned NUMBER_CLAUSES = 8;
    localparam int unsigned CLAUSE_WIDTH   = 4;
    localparam int unsigned VAR_WIDTH      = 4;

    // Length fields must hold the full count, index fields only count-1.
    localparam int unsigned CLEN_W = $clog2(CLAUSE_WIDTH + 1);
    localparam int unsigned FLEN_W = $clog2(NUMBER_CLAUSES + 1);
    localparam int unsigned LIDX_W = $clog2(CLAUSE_WIDTH);
    localparam int unsigned CIDX_W = $clog2(NUMBER_CLAUSES);

    // 'var' is a keyword, so the variable number field is called vid.
    typedef struct packed {
        logic                 neg;
        logic [VAR_WIDTH-1:0] vid;
    } lit_t;

    typedef struct packed {
        lit_t [CLAUSE_WIDTH-1:0] lits;
        logic [CLEN_W-1:0]       len;
    } clause_t;

    typedef struct packed {
        clause_t [NUMBER_CLAUSES-1:0] clauses;
        logic [FLEN_W-1:0]            len;
    } formula_t;

    localparam lit_t     ZERO_LIT     = '0;
    localparam clause_t  ZERO_CLAUSE  = '0;
    localparam formula_t ZERO_FORMULA = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Negation flips polarity only; the variable number is kept.
    function automatic lit_t lit_neg(input lit_t l);
        lit_t r;
        r     = l;
        r.neg = ~l.neg;
        return r;
    endfunction

endpackage

// File: rtl/unit_propagate_clause_reduce.sv
// Combinational reduction of one clause against an assigned literal.
// Ports:
//   clause_i       clause under examination (only lits[0..len-1] are used)
//   lit_i          literal assigned true
//   satisfied_c_o  clause contains lit_i -> whole clause is dropped
//   reduced_c_o    clause with every occurrence of the negated literal removed,
//                  survivors compacted in original order, upper slots zero
//   empty_c_o      not satisfied and nothing survived (conflict)
module unit_propagate_clause_reduce
    import unit_propagate_pkg::*;
(
    input  clause_t clause_i,
    input  lit_t    lit_i,
    output logic    satisfied_c_o,
    output clause_t reduced_c_o,
    output logic    empty_c_o
);

    lit_t              neg_lit;
    logic [CLEN_W-1:0] keep_cnt;

    // Walk the valid slots, packing kept literals at the running write slot.
    always_comb begin
        neg_lit       = lit_neg(lit_i);
        satisfied_c_o = 1'b0;
        reduced_c_o   = ZERO_CLAUSE;
        keep_cnt      = '0;
        for (int k = 0; k < int'(CLAUSE_WIDTH); k++) begin
            if (CLEN_W'(k) < clause_i.len) begin
                if (clause_i.lits[LIDX_W'(k)] == lit_i) begin
                    satisfied_c_o = 1'b1;
                end else if (clause_i.lits[LIDX_W'(k)] != neg_lit) begin
                    reduced_c_o.lits[LIDX_W'(keep_cnt)] = clause_i.lits[LIDX_W'(k)];
                    keep_cnt = keep_cnt + CLEN_W'(1);
                end
            end
        end
        reduced_c_o.len = keep_cnt;
        empty_c_o       = !satisfied_c_o && (keep_cnt == '0);
    end

endmodule

// File: rtl/unit_propagate.sv
// Applies one assigned literal to a CNF formula: scans one clause per cycle,
// drops satisfied clauses, strips falsified literals and reports conflict
// (empty clause) or satisfaction (empty formula).
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               request, sampled only while idle
//   in_formula, in_lit  formula and true literal, captured at accept
//   ended               one-cycle pulse, result valid
//   conflict, sat       result flags, held until next accept
//   out_formula         simplified formula, held until next accept
module unit_propagate
    import unit_propagate_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     start,
    input  formula_t in_formula,
    input  lit_t     in_lit,
    output logic     ended,
    output logic     conflict,
    output logic     sat,
    output formula_t out_formula
);

    state_e            state_q, state_d;
    formula_t          form_q, form_d;
    lit_t              lit_q, lit_d;
    logic [FLEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [FLEN_W-1:0] wr_idx_q, wr_idx_d;
    formula_t          out_q, out_d;
    logic              conflict_q, conflict_d;
    logic              sat_q, sat_d;
    logic              ended_q, ended_d;

    logic [FLEN_W-1:0] scan_len;
    clause_t           cur_clause;
    logic              red_sat;
    logic              red_empty;
    clause_t           red_clause;
    logic              finish;

    // A length beyond capacity is clamped so the read index stays in range.
    assign scan_len   = (form_q.len > FLEN_W'(NUMBER_CLAUSES)) ? FLEN_W'(NUMBER_CLAUSES)
                                                                 : form_q.len;
    assign cur_clause = form_q.clauses[CIDX_W'(rd_idx_q)];

    unit_propagate_clause_reduce u_clause_reduce (
        .clause_i      (cur_clause),
        .lit_i         (lit_q),
        .satisfied_c_o (red_sat),
        .reduced_c_o   (red_clause),
        .empty_c_o     (red_empty)
    );

    // Next-state and result logic.
    always_comb begin
        state_d    = state_q;
        form_d     = form_q;
        lit_d      = lit_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        out_d      = out_q;
        conflict_d = conflict_q;
        sat_d      = sat_q;
        ended_d    = 1'b0;
        finish     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    form_d     = in_formula;
                    lit_d      = in_lit;
                    rd_idx_d   = '0;
                    wr_idx_d   = '0;
                    conflict_d = 1'b0;
                    sat_d      = 1'b0;
                    out_d      = ZERO_FORMULA;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (rd_idx_q >= scan_len) begin
                    // Only reachable for an empty input formula.
                    finish = 1'b1;
                end else begin
                    if (!red_sat) begin
                        if (red_empty) begin
                            conflict_d = 1'b1;
                            finish     = 1'b1;
                        end else begin
                            out_d.clauses[CIDX_W'(wr_idx_q)] = red_clause;
                            wr_idx_d = wr_idx_q + FLEN_W'(1);
                        end
                    end
                    rd_idx_d = rd_idx_q + FLEN_W'(1);
                    if (rd_idx_d == scan_len) begin
                        finish = 1'b1;
                    end
                end

                if (finish) begin
                    out_d.len = wr_idx_d;
                    sat_d     = (wr_idx_d == '0) && !conflict_d;
                    ended_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            form_q     <= ZERO_FORMULA;
            lit_q      <= ZERO_LIT;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            out_q      <= ZERO_FORMULA;
            conflict_q <= 1'b0;
            sat_q      <= 1'b0;
            ended_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            form_q     <= form_d;
            lit_q      <= lit_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            out_q      <= out_d;
            conflict_q <= conflict_d;
            sat_q      <= sat_d;
            ended_q    <= ended_d;
        end
    end

    assign ended       = ended_q;
    assign conflict    = conflict_q;
    assign sat         = sat_q;
    assign out_formula = out_q;

endmodule
